// File: rtl/interp_request_ctrl_pkg.sv
// Shared types and constants for the interpolation request controller.
package interp_request_ctrl_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int FRAC_DEF  = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_ALU     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/interp_request_ctrl_table.sv
// Sample-point register file: one write port, two combinational read ports
// returning the pair (raddr, raddr+1) that the search walks over.
module interp_point_table #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wt,
  input  logic [WIDTH-1:0] wu,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] lo_t,
  output logic [WIDTH-1:0] lo_u,
  output logic [WIDTH-1:0] hi_t,
  output logic [WIDTH-1:0] hi_u
);

  logic [WIDTH-1:0] t_q [DEPTH];
  logic [WIDTH-1:0] t_d [DEPTH];
  logic [WIDTH-1:0] u_q [DEPTH];
  logic [WIDTH-1:0] u_d [DEPTH];
  logic [AW-1:0]    raddr_hi;

  // Next table contents: hold everything, overwrite the addressed entry on a write.
  always_comb begin
    t_d = t_q;
    u_d = u_q;
    if (we && (int'(waddr) < DEPTH)) begin
      t_d[waddr] = wt;
      u_d[waddr] = wu;
    end
  end

  // Table storage is deliberately not reset so a controller reset keeps the samples.
  always_ff @(posedge clk) begin
    t_q <= t_d;
    u_q <= u_d;
  end

  assign raddr_hi = raddr + 1'b1;
  assign lo_t     = t_q[raddr];
  assign lo_u     = u_q[raddr];
  assign hi_t     = t_q[raddr_hi];
  assign hi_u     = u_q[raddr_hi];

endmodule

// File: rtl/interp_request_ctrl.sv
// Initiator-side controller for the interpolation ALU: finds the bracketing
// sample pair for a requested Tk, runs the ALU handshake and returns Uk.
module interp_request_ctrl
  import interp_request_ctrl_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int FRAC    = FRAC_DEF,
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tbl_we,
  input  logic [AW-1:0]    tbl_addr,
  input  logic [WIDTH-1:0] tbl_t,
  input  logic [WIDTH-1:0] tbl_u,
  input  logic [AW:0]      num_pts,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_tk,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_uk,
  output logic [1:0]       rsp_err,
  output logic [WIDTH-1:0] alu_tk,
  output logic [WIDTH-1:0] alu_tn,
  output logic [WIDTH-1:0] alu_tz,
  output logic [WIDTH-1:0] alu_uz,
  output logic [WIDTH-1:0] alu_un,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_uk,
  input  logic             alu_error,
  input  logic             alu_ready
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  // FRAC only documents the number format; the ALU owns the arithmetic.
  if (FRAC >= WIDTH) begin : g_frac_check
    $error("FRAC must be smaller than WIDTH");
  end

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] tk_q, tk_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] rsp_uk_q, rsp_uk_d;
  logic [1:0]       rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] alu_tk_q, alu_tk_d, alu_tn_q, alu_tn_d, alu_tz_q, alu_tz_d;
  logic [WIDTH-1:0] alu_uz_q, alu_uz_d, alu_un_q, alu_un_d;
  logic [WIDTH-1:0] lo_t, lo_u, hi_t, hi_u;
  logic             in_pair, last_pair, timed_out;

  interp_point_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_table (
    .clk   (clk),
    .we    (tbl_we && (state_q == S_IDLE)),
    .waddr (tbl_addr),
    .wt    (tbl_t),
    .wu    (tbl_u),
    .raddr (idx_q),
    .lo_t  (lo_t),
    .lo_u  (lo_u),
    .hi_t  (hi_t),
    .hi_u  (hi_u)
  );

  assign in_pair   = ($signed(lo_t) <= $signed(tk_q)) && ($signed(tk_q) <= $signed(hi_t));
  assign last_pair = ({1'b0, idx_q} == (num_pts - (AW+1)'(2))) || (idx_q == AW'(DEPTH - 2));
  assign cnt_inc   = cnt_q + CW'(1);
  assign timed_out = (cnt_inc == CW'(TIMEOUT - 1));

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      tk_q      <= '0;
      cnt_q     <= '0;
      rsp_uk_q  <= '0;
      rsp_err_q <= ERR_OK;
      alu_tk_q  <= '0;
      alu_tn_q  <= '0;
      alu_tz_q  <= '0;
      alu_uz_q  <= '0;
      alu_un_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tk_q      <= tk_d;
      cnt_q     <= cnt_d;
      rsp_uk_q  <= rsp_uk_d;
      rsp_err_q <= rsp_err_d;
      alu_tk_q  <= alu_tk_d;
      alu_tn_q  <= alu_tn_d;
      alu_tz_q  <= alu_tz_d;
      alu_uz_q  <= alu_uz_d;
      alu_un_q  <= alu_un_d;
    end
  end

  // Next state: scan one pair per cycle, then issue, wait for busy, wait for done.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tk_d      = tk_q;
    cnt_d     = cnt_q;
    rsp_uk_d  = rsp_uk_q;
    rsp_err_d = rsp_err_q;
    alu_tk_d  = alu_tk_q;
    alu_tn_d  = alu_tn_q;
    alu_tz_d  = alu_tz_q;
    alu_uz_d  = alu_uz_q;
    alu_un_d  = alu_un_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          tk_d    = req_tk;
          idx_d   = '0;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (num_pts < (AW+1)'(2)) begin
          rsp_err_d = ERR_RANGE;
          rsp_uk_d  = '0;
          state_d   = S_RESP;
        end else if (in_pair) begin
          alu_tk_d = tk_q;
          alu_tn_d = lo_t;
          alu_tz_d = hi_t;
          alu_un_d = lo_u;
          alu_uz_d = hi_u;
          state_d  = S_ISSUE;
        end else if (last_pair) begin
          rsp_err_d = ERR_RANGE;
          rsp_uk_d  = '0;
          state_d   = S_RESP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        cnt_d = cnt_inc;
        if (!alu_ready) begin
          state_d = S_WAIT_DONE;
        end else if (timed_out) begin
          rsp_err_d = ERR_TIMEOUT;
          rsp_uk_d  = '0;
          state_d   = S_RESP;
        end
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_inc;
        if (alu_ready) begin
          rsp_err_d = alu_error ? ERR_ALU : ERR_OK;
          rsp_uk_d  = alu_error ? '0 : alu_uk;
          state_d   = S_RESP;
        end else if (timed_out) begin
          rsp_err_d = ERR_TIMEOUT;
          rsp_uk_d  = '0;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    req_ready = 1'b0;
    alu_start = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      S_IDLE:  req_ready = 1'b1;
      S_ISSUE: alu_start = 1'b1;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_uk  = rsp_uk_q;
  assign rsp_err = rsp_err_q;
  assign alu_tk  = alu_tk_q;
  assign alu_tn  = alu_tn_q;
  assign alu_tz  = alu_tz_q;
  assign alu_uz  = alu_uz_q;
  assign alu_un  = alu_un_q;

endmodule

// File: tb/tb_interp_request_ctrl.sv
// Self-checking bench for interp_request_ctrl with a behavioural ALU stub
// and a table-level model of the expected search / handshake behaviour.
module tb_interp_request_ctrl;

  localparam int TB_TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tbl_we = 1'b0;
  logic [2:0]  tbl_addr = '0;
  logic [15:0] tbl_t = '0;
  logic [15:0] tbl_u = '0;
  logic [3:0]  num_pts = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_tk = '0;
  logic        rsp_valid;
  logic [15:0] rsp_uk;
  logic [1:0]  rsp_err;
  logic [15:0] alu_tk, alu_tn, alu_tz, alu_uz, alu_un;
  logic        alu_start;
  logic [15:0] alu_uk = '0;
  logic        alu_error = 1'b0;
  logic        alu_ready = 1'b1;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model state: table, request expectations, operand expectations.
  int m_t [8];
  int m_u [8];
  int m_n = 0;
  int m_err = 0;
  int m_uk = 0;
  int exp_start = -100;
  int exp_rsp = -100;
  int busy_lo = -100;
  int busy_hi = -101;
  int op_cur [5] = '{0, 0, 0, 0, 0};
  int op_next [5] = '{0, 0, 0, 0, 0};
  int rsp_cnt = 0;
  int cap_uk = 0;
  int cap_err = 0;
  int sel [5];

  // ALU stub configuration: 0 normal, 1 ready stuck high, 2 ready drops and never returns.
  int alu_mode = 0;
  int alu_lat = 3;
  int alu_cnt = 0;

  interp_request_ctrl #(
    .WIDTH   (16),
    .FRAC    (7),
    .DEPTH   (8),
    .AW      (3),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tbl_we    (tbl_we),
    .tbl_addr  (tbl_addr),
    .tbl_t     (tbl_t),
    .tbl_u     (tbl_u),
    .num_pts   (num_pts),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_tk    (req_tk),
    .rsp_valid (rsp_valid),
    .rsp_uk    (rsp_uk),
    .rsp_err   (rsp_err),
    .alu_tk    (alu_tk),
    .alu_tn    (alu_tn),
    .alu_tz    (alu_tz),
    .alu_uz    (alu_uz),
    .alu_un    (alu_un),
    .alu_start (alu_start),
    .alu_uk    (alu_uk),
    .alu_error (alu_error),
    .alu_ready (alu_ready)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Cycle index: value seen between two rising edges.
  always @(posedge clk) cyc <= cyc + 1;

  // Linear interpolation in raw fixed-point units (the scale factor cancels).
  function automatic int interp(input int tk, input int tn, input int tz, input int uz, input int un);
    return un + ((tk - tn) * (uz - un)) / (tz - tn);
  endfunction

  // First pair i with T[i] <= tk <= T[i+1], or -1 when none exists.
  function automatic int findPair(input int tk);
    if (m_n < 2) return -1;
    for (int i = 0; i < m_n - 1; i++) begin
      if (m_t[i] <= tk && tk <= m_t[i+1]) return i;
    end
    return -1;
  endfunction

  // Behavioural ALU: drops ready on start, raises it with the result alu_lat cycles later.
  always @(posedge clk) begin
    if (alu_start && alu_mode != 1) begin
      alu_ready <= 1'b0;
      alu_cnt   <= (alu_mode == 2) ? 0 : alu_lat;
      if (alu_tz == alu_tn) begin
        alu_error <= 1'b1;
        alu_uk    <= '0;
      end else begin
        alu_error <= 1'b0;
        alu_uk    <= 16'(interp($signed(alu_tk), $signed(alu_tn), $signed(alu_tz),
                                $signed(alu_uz), $signed(alu_un)));
      end
    end else if (alu_cnt == 1) begin
      alu_ready <= 1'b1;
      alu_cnt   <= 0;
    end else if (alu_cnt > 1) begin
      alu_cnt <= alu_cnt - 1;
    end
  end

  // Single comparison with pass/fail bookkeeping.
  task automatic check(input string name, input logic signed [31:0] got, input logic signed [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Per-cycle compare of the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", req_ready, !(cyc >= busy_lo && cyc <= busy_hi));
      check("alu_start", alu_start, cyc == exp_start);
      check("rsp_valid", rsp_valid, cyc == exp_rsp);
      if (rsp_valid === 1'b1) begin
        rsp_cnt++;
        cap_uk  = $signed(rsp_uk);
        cap_err = rsp_err;
      end
      if (cyc == exp_rsp) begin
        check("rsp_err model", rsp_err, m_err);
        check("rsp_uk model", $signed(rsp_uk), m_uk);
      end
      for (int j = 0; j < 5; j++) sel[j] = (exp_start >= 0 && cyc >= exp_start) ? op_next[j] : op_cur[j];
      check("alu_tk", $signed(alu_tk), sel[0]);
      check("alu_tn", $signed(alu_tn), sel[1]);
      check("alu_tz", $signed(alu_tz), sel[2]);
      check("alu_uz", $signed(alu_uz), sel[3]);
      check("alu_un", $signed(alu_un), sel[4]);
    end
  end

  // Table write in IDLE, mirrored into the model.
  task automatic writeEntry(input int addr, input int t, input int u);
    tbl_we   = 1'b1;
    tbl_addr = addr[2:0];
    tbl_t    = t[15:0];
    tbl_u    = u[15:0];
    m_t[addr] = t;
    m_u[addr] = u;
    @(posedge clk); #2;
    tbl_we = 1'b0;
  endtask

  task automatic setPoints(input int n);
    num_pts = n[3:0];
    m_n     = n;
  endtask

  // Literal end-of-request checks that pin the model to hand-computed values.
  task automatic checkOutput(input string name, input int exp_cnt, input int lit_err, input int lit_uk);
    check({name, " rsp count"}, rsp_cnt, exp_cnt);
    if (exp_cnt == 1) begin
      check({name, " err"}, cap_err, lit_err);
      check({name, " uk"}, cap_uk, lit_uk);
    end else begin
      check({name, " rsp_uk after reset"}, $signed(rsp_uk), 0);
      check({name, " rsp_err after reset"}, rsp_err, 0);
      check({name, " req_ready after reset"}, req_ready, 1);
    end
  endtask

  // One request: optional same-cycle table write, optional mid-job event
  // (ev_kind 1 = reset pulse, 2 = table write while busy) at ev_at cycles after issue.
  task automatic applyStimulus(input string name, input int tk, input int lit_err, input int lit_uk,
                               input bit do_we, input int we_addr, input int we_t, input int we_u,
                               input int ev_kind, input int ev_at);
    int a, p, iss, rsp, wait_until, k;
    k = 0;
    while (req_ready !== 1'b1 && k < 100) begin
      @(posedge clk); #2;
      k++;
    end
    if (req_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: req_ready never rose, got %b, expected 1", name, req_ready);
    end
    if (do_we) begin
      tbl_we   = 1'b1;
      tbl_addr = we_addr[2:0];
      tbl_t    = we_t[15:0];
      tbl_u    = we_u[15:0];
      m_t[we_addr] = we_t;
      m_u[we_addr] = we_u;
    end
    req_valid = 1'b1;
    req_tk    = tk[15:0];
    a = cyc + 1;
    p = findPair(tk);
    rsp_cnt = 0;
    for (int j = 0; j < 5; j++) op_cur[j] = op_next[j];
    if (p >= 0) begin
      iss = a + p + 1;
      op_next = '{tk, m_t[p], m_t[p+1], m_u[p+1], m_u[p]};
      if (alu_mode == 0) begin
        rsp = iss + alu_lat + 2;
        if (m_t[p] == m_t[p+1]) begin
          m_err = 2;
          m_uk  = 0;
        end else begin
          m_err = 0;
          m_uk  = interp(tk, m_t[p], m_t[p+1], m_u[p+1], m_u[p]);
        end
      end else begin
        rsp   = iss + TB_TIMEOUT;
        m_err = 3;
        m_uk  = 0;
      end
    end else begin
      iss   = -100;
      rsp   = a + ((m_n < 2) ? 1 : m_n - 1);
      m_err = 1;
      m_uk  = 0;
    end
    exp_start = iss;
    exp_rsp   = rsp;
    busy_lo   = a;
    busy_hi   = rsp;
    wait_until = (ev_kind == 1) ? iss + ev_at + 2 : rsp + 1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    tbl_we    = 1'b0;
    for (k = 0; k < 400 && cyc <= wait_until; k++) begin
      tbl_we = 1'b0;
      if (ev_kind == 2 && cyc == iss + ev_at) begin
        tbl_we   = 1'b1;
        tbl_addr = 3'd0;
        tbl_t    = 16'd100;
        tbl_u    = 16'd999;
      end
      if (ev_kind == 1 && cyc == iss + ev_at) begin
        rst_n   = 1'b0;
        exp_rsp = -100;
        busy_hi = cyc;
      end
      if (ev_kind == 1 && cyc == iss + ev_at + 1) begin
        rst_n = 1'b1;
        op_cur  = '{0, 0, 0, 0, 0};
        op_next = '{0, 0, 0, 0, 0};
        exp_start = -100;
      end
      @(posedge clk); #2;
    end
    tbl_we = 1'b0;
    if (cyc <= wait_until) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: wait bound expired at cycle %0d, expected past %0d", name, cyc, wait_until);
    end
    checkOutput(name, (ev_kind == 1) ? 0 : 1, lit_err, lit_uk);
  endtask

  // Directed test sequence.
  initial begin
    for (int i = 0; i < 8; i++) begin
      m_t[i] = 0;
      m_u[i] = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    check("reset req_ready", req_ready, 1);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_uk", $signed(rsp_uk), 0);
    check("reset rsp_err", rsp_err, 0);
    check("reset alu_start", alu_start, 0);
    check("reset alu_tn", $signed(alu_tn), 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    writeEntry(0, 0, 0);
    writeEntry(1, 128, 256);
    writeEntry(2, 256, 256);
    writeEntry(3, 384, -128);
    setPoints(4);

    applyStimulus("tk=192", 192, 0, 256, 0, 0, 0, 0, 0, 0);
    check("tk=192 pair tn", $signed(alu_tn), 128);
    check("tk=192 pair tz", $signed(alu_tz), 256);
    applyStimulus("tk=64", 64, 0, 128, 0, 0, 0, 0, 0, 0);
    applyStimulus("tk=320", 320, 0, 64, 0, 0, 0, 0, 0, 0);
    applyStimulus("tk=128 shared endpoint", 128, 0, 256, 0, 0, 0, 0, 0, 0);
    check("tk=128 pair tn", $signed(alu_tn), 0);
    check("tk=128 pair tz", $signed(alu_tz), 128);
    applyStimulus("tk=448 above range", 448, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("tk=-1 below range", -1, 1, 0, 0, 0, 0, 0, 0, 0);
    setPoints(1);
    applyStimulus("num_pts=1", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    setPoints(4);

    writeEntry(2, 128, 256);
    applyStimulus("duplicate T first pair", 128, 0, 256, 0, 0, 0, 0, 0, 0);
    writeEntry(1, 0, 256);
    applyStimulus("zero span", 0, 2, 0, 0, 0, 0, 0, 0, 0);
    writeEntry(1, 128, 256);
    writeEntry(2, 256, 256);

    alu_mode = 1;
    applyStimulus("timeout ready stuck high", 192, 3, 0, 0, 0, 0, 0, 0, 0);
    alu_mode = 2;
    applyStimulus("timeout ready stuck low", 64, 3, 0, 0, 0, 0, 0, 0, 0);
    alu_mode = 0;

    alu_lat = 8;
    applyStimulus("write while busy", 64, 0, 128, 0, 0, 0, 0, 2, 3);
    alu_lat = 3;
    applyStimulus("table after busy write", 64, 0, 128, 0, 0, 0, 0, 0, 0);

    applyStimulus("write with request", 448, 0, 160, 1, 3, 512, 128, 0, 0);
    writeEntry(3, 384, -128);

    alu_lat = 10;
    applyStimulus("reset in wait_done", 192, 0, 0, 0, 0, 0, 0, 1, 4);
    alu_lat = 3;
    applyStimulus("after reset", 320, 0, 64, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case something keeps the sequence from completing.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/interp_request_ctrl.md
Name: interp_request_ctrl

Overview:
- Initiator-side controller for the interpolation ALU (Uk = Un + (Tk-Tn)*(Uz-Un)/(Tz-Tn), signed Q(WIDTH-FRAC).FRAC).
- Holds a table of sample points (T,U) sorted ascending by T. For a requested Tk it scans for the bracketing pair and drives the ALU start/ready handshake.
- Returns Uk with a status code to the ODE-solver datapath.

Parameters:
- WIDTH, 16, data width of T/U values (signed fixed point)
- FRAC, 7, fractional bits (informational; arithmetic is done in the ALU)
- DEPTH, 8, table entries
- AW, 3, table address width, clog2(DEPTH)
- TIMEOUT, 32, max cycles waited on the ALU before abort

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- tbl_we  in  1  table write strobe; honoured only in IDLE
- tbl_addr  in  AW  table write index
- tbl_t  in  WIDTH  sample time
- tbl_u  in  WIDTH  sample value
- num_pts  in  AW+1  number of valid entries, 0..DEPTH
- req_valid  in  1  request Tk
- req_ready  out  1  high only in IDLE
- req_tk  in  WIDTH  query time
- rsp_valid  out  1  one-cycle result pulse; no backpressure
- rsp_uk  out  WIDTH  result; 0 when rsp_err != 0
- rsp_err  out  2  0=ok, 1=out of range, 2=ALU error, 3=timeout
- alu_tk, alu_tn, alu_tz, alu_uz, alu_un  out  WIDTH each  ALU operands, registered
- alu_start  out  1  one-cycle start pulse
- alu_uk  in  WIDTH  ALU result
- alu_error  in  1  ALU divide-by-zero flag
- alu_ready  in  1  ALU done

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on rst_n.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_uk=0, rsp_err=0, alu_start=0, all alu_* operands=0, timeout counter=0.
- Reset does not clear table contents. Reset mid-operation aborts immediately: no rsp_valid, alu_start low next cycle.
- States: IDLE, SEARCH, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - req_valid && req_ready → latch Tk, i=0, go to SEARCH.
  - tbl_we writes the entry in any IDLE cycle. Simultaneous tbl_we and request: write occurs, request is accepted, and the search sees the new entry.
- SEARCH, one pair per cycle:
  - num_pts<2 → RESP with err=1.
  - If signed T[i] <= Tk <= T[i+1] → load operands Tn=T[i], Tz=T[i+1], Un=U[i], Uz=U[i+1], Tk, then go to ISSUE.
  - Else if i == num_pts-2 → RESP with err=1.
  - Else i++.
  - Tk equal to a shared endpoint selects the lower pair (first match).
- ISSUE: alu_start=1 for exactly one cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY: wait for alu_ready==0. This prevents a stale ready from the previous job being taken as completion. Then go to WAIT_DONE.
- WAIT_DONE: on alu_ready==1 sample alu_uk and alu_error. Go to RESP with err=2 if alu_error, else err=0 and uk=alu_uk.
- Timeout: the counter increments in WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT-1 without an exit condition → RESP with err=3.
- RESP: rsp_valid=1 for one cycle with rsp_uk/rsp_err; go to IDLE. req_ready rises the same cycle rsp_valid falls.
- Operand ports hold their values from ISSUE until the next ISSUE.
- Latency from accept to rsp_valid: (i+1) search cycles + 1 ISSUE + ALU cycles + 1 RESP. Out-of-range: num_pts-1 search cycles + 1.
- Table order is the writer's responsibility. Unsorted tables give the first matching pair, or err=1.
- Equal adjacent T values select the pair, and the ALU reports err=2.

Decomposition:
- Shared package holds: state enum, rsp_err code constants (ERR_OK, ERR_RANGE, ERR_ALU, ERR_TIMEOUT), WIDTH/FRAC defaults.
- One sub-module: interp_point_table (DEPTH×2×WIDTH register file, one write port, two combinational read ports at i and i+1).
- The ALU is instantiated outside this block, by the parent.

Test Plan:
- Table T={0,128,256,384}, U={0,256,256,-128}, num_pts=4, real ALU; req_tk=192 → rsp_err=0, rsp_uk=256 (2.0), Tn=128/Tz=256 selected.
- Same table; req_tk=64 → rsp_uk=128 (1.0); req_tk=320 → rsp_uk=64 (0.5); req_tk=128 → pair 0 used, rsp_uk=256.
- req_tk=448 or -1 → rsp_err=1, rsp_uk=0, alu_start never pulses. num_pts=1 with req_tk=0 → rsp_err=1.
- T={0,128,128,384}, req_tk=128 → pair 0 ok (rsp_uk=256). Then T={0,0,...}, req_tk=0 → pair 0 with zero span → rsp_err=2.
- ALU stub holding alu_ready=1 forever → rsp_err=3 exactly TIMEOUT cycles after ISSUE. Stub holding ready=0 after start → rsp_err=3 likewise.
- Assert rst_n=0 for one cycle during WAIT_DONE → no rsp_valid, req_ready=1 next cycle, table intact; the next request completes correctly. tbl_we during a busy state is ignored.
